// File: rtl/cpu_ctrl_fsm_p.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_fsm_p
// Parametrised controller FSM for the simple CPU: sequences fetch, decode and
// execute, handshakes data memory through D_ack with a bounded wait, and
// supports jump, HALT/resume and a sticky ERROR state.
//
// Optional feature macro: CPU_CTRL_MUL_EN
//   defined   -> opcode 8 executes MUL (alu_op = 2'b11)
//   undefined -> no MUL state, opcode 8 is illegal and goes to ERROR
//
// Parameters
//   RF_AW   register-file address width (instruction width = 4 + 3*RF_AW)
//   D_AW    data-memory address width (must not exceed 2*RF_AW)
//   MEM_TO  maximum D_ack wait cycles before ERROR (>= 1)
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   instruction                         IR contents (opcode/ra/rb/rc/d/k)
//   RF_Rp_zero                          Rp read port is zero (for JZ)
//   D_ack                               data memory finished access
//   run                                 resume from HALT
//   PC_clr, PC_inc, PC_ld               program counter controls
//   I_rd, IR_ld                         instruction read / IR load
//   D_addr, D_rd, D_wr                  data-memory address and strobes
//   RF_W_data, RF_s                     constant data / write-data select
//   RF_W_addr, RF_Rp_addr, RF_Rq_addr   register addresses
//   RF_W_wr, RF_Rp_rd, RF_Rq_rd         register-file enables
//   alu_op                              00 none, 01 add, 10 sub, 11 mul
//   halted, err                         status: in HALT / in ERROR
//
// Outputs are decoded from the current state and instruction; only RF_W_wr
// in LOAD additionally depends on D_ack.
// ---------------------------------------------------------------------------
module cpu_ctrl_fsm_p #(
    parameter int unsigned RF_AW  = 4,
    parameter int unsigned D_AW   = 8,
    parameter int unsigned MEM_TO = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3*RF_AW+3:0]     instruction,
    input  logic                   RF_Rp_zero,
    input  logic                   D_ack,
    input  logic                   run,
    output logic                   PC_clr,
    output logic                   PC_inc,
    output logic                   PC_ld,
    output logic                   I_rd,
    output logic                   IR_ld,
    output logic [D_AW-1:0]        D_addr,
    output logic                   D_rd,
    output logic                   D_wr,
    output logic [2*RF_AW-1:0]     RF_W_data,
    output logic [1:0]             RF_s,
    output logic [RF_AW-1:0]       RF_W_addr,
    output logic [RF_AW-1:0]       RF_Rp_addr,
    output logic [RF_AW-1:0]       RF_Rq_addr,
    output logic                   RF_W_wr,
    output logic                   RF_Rp_rd,
    output logic                   RF_Rq_rd,
    output logic [1:0]             alu_op,
    output logic                   halted,
    output logic                   err
);

    localparam int unsigned IW = 4 + 3*RF_AW;
    localparam int unsigned CW = $clog2(MEM_TO + 1);

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_LOAD_CONST,
        S_SUB,
        S_JZ,
        S_JZ_JMP,
        S_JMP,
        S_HALT,
        S_ERROR
`ifdef CPU_CTRL_MUL_EN
        ,
        S_MUL
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_wait;
    logic [CW-1:0]   w_wait_nxt;

    // Instruction field extraction
    logic [3:0]          w_opcode;
    logic [RF_AW-1:0]    w_ra;
    logic [RF_AW-1:0]    w_rb;
    logic [RF_AW-1:0]    w_rc;
    logic [D_AW-1:0]     w_d;
    logic [2*RF_AW-1:0]  w_k;
    logic                w_timeout;

    assign w_opcode = instruction[IW-1 -: 4];
    assign w_ra     = instruction[3*RF_AW-1 -: RF_AW];
    assign w_rb     = instruction[2*RF_AW-1 -: RF_AW];
    assign w_rc     = instruction[RF_AW-1:0];
    assign w_d      = instruction[D_AW-1:0];
    assign w_k      = instruction[2*RF_AW-1:0];

    // Memory wait has used its whole budget and still no acknowledge
    assign w_timeout = (r_wait == CW'(MEM_TO)) && !D_ack;

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = '0;
        PC_clr      = 1'b0;
        PC_inc      = 1'b0;
        PC_ld       = 1'b0;
        I_rd        = 1'b0;
        IR_ld       = 1'b0;
        D_addr      = '0;
        D_rd        = 1'b0;
        D_wr        = 1'b0;
        RF_W_data   = '0;
        RF_s        = 2'b00;
        RF_W_addr   = '0;
        RF_Rp_addr  = '0;
        RF_Rq_addr  = '0;
        RF_W_wr     = 1'b0;
        RF_Rp_rd    = 1'b0;
        RF_Rq_rd    = 1'b0;
        alu_op      = 2'b00;
        halted      = 1'b0;
        err         = 1'b0;

        case (r_state)
            S_INIT: begin
                PC_clr      = 1'b1;
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                PC_inc      = 1'b1;
                I_rd        = 1'b1;
                IR_ld       = 1'b1;
                w_state_nxt = S_DECODE;
            end

            // Counter leaves DECODE at zero, so every LOAD/STORE starts fresh
            S_DECODE: begin
                case (w_opcode)
                    4'd0:    w_state_nxt = S_LOAD;
                    4'd1:    w_state_nxt = S_STORE;
                    4'd2:    w_state_nxt = S_ADD;
                    4'd3:    w_state_nxt = S_LOAD_CONST;
                    4'd4:    w_state_nxt = S_SUB;
                    4'd5:    w_state_nxt = S_JZ;
                    4'd6:    w_state_nxt = S_JMP;
                    4'd7:    w_state_nxt = S_HALT;
`ifdef CPU_CTRL_MUL_EN
                    4'd8:    w_state_nxt = S_MUL;
`endif
                    default: w_state_nxt = S_ERROR;
                endcase
            end

            // Register write happens only in the acknowledge cycle
            S_LOAD: begin
                D_addr    = w_d;
                D_rd      = 1'b1;
                RF_s      = 2'b01;
                RF_W_addr = w_ra;
                if (D_ack) begin
                    RF_W_wr     = 1'b1;
                    w_state_nxt = S_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_wait_nxt  = r_wait + CW'(1);
                end
            end

            S_STORE: begin
                D_addr     = w_d;
                D_wr       = 1'b1;
                RF_Rp_addr = w_ra;
                RF_Rp_rd   = 1'b1;
                if (D_ack) begin
                    w_state_nxt = S_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_wait_nxt  = r_wait + CW'(1);
                end
            end

            S_ADD: begin
                RF_Rp_addr  = w_rb;
                RF_Rq_addr  = w_rc;
                RF_Rp_rd    = 1'b1;
                RF_Rq_rd    = 1'b1;
                RF_W_addr   = w_ra;
                RF_W_wr     = 1'b1;
                alu_op      = 2'b01;
                w_state_nxt = S_FETCH;
            end

            S_SUB: begin
                RF_Rp_addr  = w_rb;
                RF_Rq_addr  = w_rc;
                RF_Rp_rd    = 1'b1;
                RF_Rq_rd    = 1'b1;
                RF_W_addr   = w_ra;
                RF_W_wr     = 1'b1;
                alu_op      = 2'b10;
                w_state_nxt = S_FETCH;
            end

`ifdef CPU_CTRL_MUL_EN
            S_MUL: begin
                RF_Rp_addr  = w_rb;
                RF_Rq_addr  = w_rc;
                RF_Rp_rd    = 1'b1;
                RF_Rq_rd    = 1'b1;
                RF_W_addr   = w_ra;
                RF_W_wr     = 1'b1;
                alu_op      = 2'b11;
                w_state_nxt = S_FETCH;
            end
`endif

            S_LOAD_CONST: begin
                RF_s        = 2'b10;
                RF_W_data   = w_k;
                RF_W_addr   = w_ra;
                RF_W_wr     = 1'b1;
                w_state_nxt = S_FETCH;
            end

            S_JZ: begin
                RF_Rp_addr  = w_ra;
                RF_Rp_rd    = 1'b1;
                w_state_nxt = RF_Rp_zero ? S_JZ_JMP : S_FETCH;
            end

            S_JZ_JMP, S_JMP: begin
                PC_ld       = 1'b1;
                w_state_nxt = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
                if (run) begin
                    w_state_nxt = S_FETCH;
                end
            end

            // Sticky: only reset leaves ERROR
            S_ERROR: begin
                err = 1'b1;
            end

            // Unused encodings fall into the safe sticky state
            default: begin
                w_state_nxt = S_ERROR;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm_p.sv
module tb_cpu_ctrl_fsm_p;

    localparam int unsigned RF_AW  = 4;
    localparam int unsigned D_AW   = 8;
    localparam int unsigned MEM_TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instruction;
    logic        RF_Rp_zero;
    logic        D_ack;
    logic        run;
    logic        PC_clr, PC_inc, PC_ld, I_rd, IR_ld;
    logic [7:0]  D_addr;
    logic        D_rd, D_wr;
    logic [7:0]  RF_W_data;
    logic [1:0]  RF_s;
    logic [3:0]  RF_W_addr, RF_Rp_addr, RF_Rq_addr;
    logic        RF_W_wr, RF_Rp_rd, RF_Rq_rd;
    logic [1:0]  alu_op;
    logic        halted, err;

    always #5 clk = ~clk;

    cpu_ctrl_fsm_p #(
        .RF_AW  (RF_AW),
        .D_AW   (D_AW),
        .MEM_TO (MEM_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .RF_Rp_zero (RF_Rp_zero),
        .D_ack      (D_ack),
        .run        (run),
        .PC_clr     (PC_clr),
        .PC_inc     (PC_inc),
        .PC_ld      (PC_ld),
        .I_rd       (I_rd),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_rd       (D_rd),
        .D_wr       (D_wr),
        .RF_W_data  (RF_W_data),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_Rp_addr (RF_Rp_addr),
        .RF_Rq_addr (RF_Rq_addr),
        .RF_W_wr    (RF_W_wr),
        .RF_Rp_rd   (RF_Rp_rd),
        .RF_Rq_rd   (RF_Rq_rd),
        .alu_op     (alu_op),
        .halted     (halted),
        .err        (err)
    );

    typedef struct packed {
        logic       pc_clr, pc_inc, pc_ld, i_rd, ir_ld;
        logic [7:0] d_addr;
        logic       d_rd, d_wr;
        logic [7:0] w_data;
        logic [1:0] rf_s;
        logic [3:0] w_addr, p_addr, q_addr;
        logic       w_wr, p_rd, q_rd;
        logic [1:0] alu_op;
        logic       halted, err;
    } out_t;

    out_t act;
    assign act = {PC_clr, PC_inc, PC_ld, I_rd, IR_ld, D_addr, D_rd, D_wr,
                  RF_W_data, RF_s, RF_W_addr, RF_Rp_addr, RF_Rq_addr,
                  RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_op, halted, err};

    out_t exp_q[$];
    int   tag_q[$];
    int   checks  = 0;
    int   passes  = 0;
    int   n_instr = 0;

    // Monitor: one expected output vector per clock, compared mid-cycle
    initial begin
        out_t e;
        int   t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (act === e) passes++;
                else $display("FAIL outputs instr#%0d got %h expected %h", t, act, e);
            end
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus plus the response the controller must show in it
    task automatic cyc(input logic [15:0] ins, input logic ack, input logic zero,
                       input logic rn, input logic rstn, input out_t e);
        @(posedge clk);
        #1;
        instruction = ins;
        D_ack       = ack;
        RF_Rp_zero  = zero;
        run         = rn;
        rst_n       = rstn;
        exp_q.push_back(e);
        tag_q.push_back(n_instr);
    endtask

    function automatic out_t e_init();
        out_t e = '0;
        e.pc_clr = 1'b1;
        return e;
    endfunction

    function automatic out_t e_fetch();
        out_t e = '0;
        e.pc_inc = 1'b1;
        e.i_rd   = 1'b1;
        e.ir_ld  = 1'b1;
        return e;
    endfunction

    function automatic out_t e_alu(input logic [15:0] ins, input logic [1:0] op);
        out_t e = '0;
        e.p_addr = ins[7:4];
        e.q_addr = ins[3:0];
        e.p_rd   = 1'b1;
        e.q_rd   = 1'b1;
        e.w_addr = ins[11:8];
        e.w_wr   = 1'b1;
        e.alu_op = op;
        return e;
    endfunction

    function automatic out_t e_mem(input logic [15:0] ins, input logic is_load, input logic ackd);
        out_t e = '0;
        e.d_addr = ins[7:0];
        if (is_load) begin
            e.d_rd   = 1'b1;
            e.rf_s   = 2'b01;
            e.w_addr = ins[11:8];
            e.w_wr   = ackd;
        end else begin
            e.d_wr   = 1'b1;
            e.p_addr = ins[11:8];
            e.p_rd   = 1'b1;
        end
        return e;
    endfunction

    // Reset asserted mid-cycle, held one clock, released mid-cycle
    task automatic reset_seq(input logic [15:0] ins);
        cyc(ins, rbit(), rbit(), rbit(), 1'b0, e_init());
        cyc(ins, rbit(), rbit(), rbit(), 1'b1, e_init());
    endtask

    // Sticky error: ignores run and D_ack until reset
    task automatic err_seq(input logic [15:0] ins);
        out_t e = '0;
        e.err = 1'b1;
        repeat (3) cyc(ins, rbit(), rbit(), 1'b1, 1'b1, e);
        reset_seq(ins);
    endtask

    // Memory access acknowledged after w idle cycles; beyond MEM_TO it times out
    task automatic mem(input logic [15:0] ins, input logic is_load, input int w);
        int n;
        n = (w > int'(MEM_TO)) ? int'(MEM_TO) + 1 : w + 1;
        for (int i = 0; i < n; i++)
            cyc(ins, (i == w), rbit(), rbit(), 1'b1, e_mem(ins, is_load, (i == w)));
        if (w > int'(MEM_TO)) err_seq(ins);
    endtask

    // Full instruction from FETCH until the controller is ready to fetch again
    task automatic issue(input logic [15:0] ins, input int w, input logic zero, input int hn);
        out_t e;
        n_instr++;
        cyc(ins, rbit(), rbit(), rbit(), 1'b1, e_fetch());
        cyc(ins, rbit(), rbit(), rbit(), 1'b1, '0);
        case (ins[15:12])
            4'd0: mem(ins, 1'b1, w);
            4'd1: mem(ins, 1'b0, w);
            4'd2: cyc(ins, rbit(), rbit(), rbit(), 1'b1, e_alu(ins, 2'b01));
            4'd3: begin
                e = '0;
                e.rf_s   = 2'b10;
                e.w_data = ins[7:0];
                e.w_addr = ins[11:8];
                e.w_wr   = 1'b1;
                cyc(ins, rbit(), rbit(), rbit(), 1'b1, e);
            end
            4'd4: cyc(ins, rbit(), rbit(), rbit(), 1'b1, e_alu(ins, 2'b10));
            4'd5: begin
                e = '0;
                e.p_addr = ins[11:8];
                e.p_rd   = 1'b1;
                cyc(ins, rbit(), zero, rbit(), 1'b1, e);
                if (zero) begin
                    e = '0;
                    e.pc_ld = 1'b1;
                    cyc(ins, rbit(), rbit(), rbit(), 1'b1, e);
                end
            end
            4'd6: begin
                e = '0;
                e.pc_ld = 1'b1;
                cyc(ins, rbit(), rbit(), rbit(), 1'b1, e);
            end
            4'd7: begin
                e = '0;
                e.halted = 1'b1;
                for (int i = 0; i < hn; i++) cyc(ins, rbit(), rbit(), 1'b0, 1'b1, e);
                cyc(ins, rbit(), rbit(), 1'b1, 1'b1, e);
            end
`ifdef CPU_CTRL_MUL_EN
            4'd8: cyc(ins, rbit(), rbit(), rbit(), 1'b1, e_alu(ins, 2'b11));
`endif
            default: err_seq(ins);
        endcase
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] ins;
        int          w;
        rst_n       = 1'b1;
        instruction = '0;
        RF_Rp_zero  = 1'b0;
        D_ack       = 1'b0;
        run         = 1'b0;
        #2 rst_n = 1'b0;
        reset_seq(16'h0000);

        issue(16'h2123, 0, 1'b0, 0);
        issue(16'h0A40, 3, 1'b0, 0);
        issue(16'h5300, 0, 1'b1, 0);
        issue(16'h5300, 0, 1'b0, 0);
        issue(16'h7000, 0, 1'b0, 10);
        issue(16'h8123, 0, 1'b0, 0);
        issue(16'h3A5C, 0, 1'b0, 0);
        issue(16'h6000, 0, 1'b0, 0);

        // Reset in the middle of a LOAD memory wait
        n_instr++;
        cyc(16'h0A40, 1'b0, 1'b0, 1'b0, 1'b1, e_fetch());
        cyc(16'h0A40, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        cyc(16'h0A40, 1'b0, 1'b0, 1'b0, 1'b1, e_mem(16'h0A40, 1'b1, 1'b0));
        cyc(16'h0A40, 1'b0, 1'b0, 1'b0, 1'b1, e_mem(16'h0A40, 1'b1, 1'b0));
        reset_seq(16'h0A40);

        issue(16'h1540, int'(MEM_TO) + 1, 1'b0, 0);
        issue(16'h0A40, int'(MEM_TO), 1'b0, 0);
        issue(16'h1540, int'(MEM_TO), 1'b0, 0);
        issue(16'hF000, 0, 1'b0, 0);

        for (int i = 0; i < 250; i++) begin
            op  = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            ins = {op, 12'($urandom())};
            case ($urandom_range(0, 19))
                0:       w = int'(MEM_TO) + 1;
                1:       w = int'(MEM_TO);
                default: w = int'($urandom_range(0, 3));
            endcase
            issue(ins, w, rbit(), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
